rgb_luma_pipe: RTL and testbench
================================

Name: rgb_luma_pipe

Overview:
- Downstream consumer of the 8-bit RGB composite pixel (r, g, b fields) produced by the pixel source stage.
- Converts each pixel to 8-bit luma Y = (COEF_R*R + COEF_G*G + COEF_B*B + rnd) >> 8 through a 2-stage valid/ready pipeline.
- Full throughput of 1 pixel/cycle; back-pressure propagates to the source.
- Counts delivered pixels for the downstream stats/debug consumer.

Parameters:
- COEF_R, 77, red weight. Unsigned, 8 bits.
- COEF_G, 150, green weight. Unsigned, 8 bits.
- COEF_B, 29, blue weight. Unsigned, 8 bits. COEF_R+COEF_G+COEF_B must equal 256. Elaboration error otherwise.
- ROUND, 1, 1 adds 128 before the >>8; 0 truncates.
- CNT_W, 16, width of the delivered-pixel counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_r  in  8  input pixel red.
- in_g  in  8  input pixel green.
- in_b  in  8  input pixel blue.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts the input pixel this cycle.
- out_y  out  8  luma result.
- out_valid  out  1  out_y valid.
- out_ready  in  1  downstream accepts out_y.
- pix_cnt  out  CNT_W  number of completed output transfers, wraps modulo 2^CNT_W.

Behaviour:
- Interface and reset:
  - One clock. Reset is asynchronous and active-low.
  - While rst_n=0: s1_valid=0, out_valid=0, out_y=0, pix_cnt=0, all product registers=0.
  - in_ready is combinational and equals 0 during reset.
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- Stage 1 (s1):
  - On input transfer, register pr = COEF_R*in_r, pg = COEF_G*in_g, pb = COEF_B*in_b. Each is 16 bits, zero-extended.
  - Set s1_valid=1.
- Stage 2 (output register):
  - sum = pr+pg+pb+(ROUND?128:0), 16 bits. No overflow is possible: max 65280+128 < 65536.
  - out_y <= sum[15:8]. The maximum result is 255.
- Advance rules, all combinational:
  - s2_free = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free.
- Per-cycle register updates:
  - On s1_adv: out_valid<=1 and out_y<=f(s1).
  - Otherwise, on output transfer: out_valid<=0.
  - s1_valid <= input transfer ? 1 : (s1_adv ? 0 : s1_valid).
- Latency and throughput:
  - 2 cycles from input transfer to out_valid=1 when out_ready stays high.
  - Sustains 1 pixel/cycle with in_valid=out_ready=1 continuously.
- Stall:
  - While out_valid=1 and out_ready=0, out_y and out_valid hold stable.
  - s1 holds its data; in_ready=0 once s1 is full.
  - No pixel is dropped or duplicated.
- Order: output order equals input order.
- Simultaneous events: output transfer, s1 advance and input transfer may all occur in the same cycle; all three complete.
- pix_cnt:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0 with no sticky flag.
- Reset mid-operation: all in-flight pixels are discarded and pix_cnt clears. After rst_n rises, the first pixel appears 2 cycles after its input transfer.
- in_valid is not required to be held by the source. No X on outputs after reset.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle, then release -> out_valid=0, out_y=0, pix_cnt=0, in_ready=1 on the first cycle after release.
- Coefficients, ROUND=1, out_ready=1, back-to-back inputs:
  - (255,255,255) -> 255
  - (255,0,0) -> 77
  - (0,255,0) -> 149
  - (0,0,255) -> 29
  - (0,0,0) -> 0
  - Outputs arrive in order, each 2 cycles after its input; pix_cnt=5 at the end.
- Truncation: ROUND=0 with (255,0,0) -> 76; with (1,1,1) -> 1.
- Back-pressure:
  - Stream 10 random pixels with in_valid=1 while out_ready toggles on a pattern (1,0,0,1,0,...).
  - Scoreboard matches a reference model exactly and in order.
  - in_ready drops only when s1 is full and out_ready=0; out_y stays stable while stalled.
- Counter wrap: CNT_W=4, 17 output transfers -> pix_cnt sequence reaches 15, then 0, then 1.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid drops immediately. The next input (10,20,30) after reset yields Y=(770+3000+870+128)>>8=18, and pix_cnt=1.

Source files
------------

// File: rtl/rgb_luma_pipe.sv
// rgb_luma_pipe: 8-bit RGB to 8-bit luma, two-stage valid/ready pipeline.
// Stage 1 registers the three weighted products; stage 2 sums, rounds
// and registers the luma byte. A delivered-pixel counter tracks output
// transfers for stats/debug.
module rgb_luma_pipe #(
  parameter logic [7:0]  COEF_R = 8'd77,
  parameter logic [7:0]  COEF_G = 8'd150,
  parameter logic [7:0]  COEF_B = 8'd29,
  parameter int unsigned ROUND  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pix_cnt
);

  // Weights must form a unity-gain sum so the result fits in 8 bits.
  if ((int'(COEF_R) + int'(COEF_G) + int'(COEF_B)) != 256) begin : g_coef_check
    $error("rgb_luma_pipe: COEF_R + COEF_G + COEF_B must equal 256");
  end

  logic [7:0]       w_coef [3];
  logic [7:0]       w_px   [3];
  logic [15:0]      w_prod [3];
  logic [15:0]      r_prod [3];
  logic             r_s1_valid;
  logic             r_out_valid;
  logic [7:0]       r_out_y;
  logic [CNT_W-1:0] r_pix_cnt;

  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [15:0]      w_rnd;
  logic [15:0]      w_sum;
  logic [7:0]       w_y;

  assign w_coef[0] = COEF_R;
  assign w_coef[1] = COEF_G;
  assign w_coef[2] = COEF_B;
  assign w_px[0]   = in_r;
  assign w_px[1]   = in_g;
  assign w_px[2]   = in_b;

  // Handshake: stage 2 can take new data when empty or draining this cycle;
  // stage 1 can take new data when empty or moving forward this cycle.
  assign w_s2_free  = !r_out_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign in_ready   = rst_n && (!r_s1_valid || w_s2_free);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Per-channel product: 8x8 unsigned, zero-extended to 16 bits.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_chan
    assign w_prod[gi] = 16'(w_coef[gi]) * 16'(w_px[gi]);

    // Stage-1 product register, loaded on every accepted input pixel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prod[gi] <= 16'd0;
      end else if (w_in_xfer) begin
        r_prod[gi] <= w_prod[gi];
      end
    end
  end

  // Weighted sum cannot overflow: 255*256 + 128 < 65536.
  assign w_rnd = (ROUND != 0) ? 16'd128 : 16'd0;
  assign w_sum = r_prod[0] + r_prod[1] + r_prod[2] + w_rnd;
  assign w_y   = 8'(w_sum >> 8);

  // Stage-1 occupancy: fill on input, empty when it advances without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Output register: load luma on advance, clear valid once delivered, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_y     <= 8'd0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_y     <= w_y;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Delivered-pixel counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= '0;
    end else if (w_out_xfer) begin
      r_pix_cnt <= r_pix_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign pix_cnt   = r_pix_cnt;

endmodule

// File: tb/tb_rgb_luma_pipe.sv
// Directed bench for rgb_luma_pipe. Three instances share one stimulus
// stream: default (rounding, 16-bit counter), truncating, and 4-bit counter.
module tb_rgb_luma_pipe;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_a, in_ready_t, in_ready_w;
  logic [7:0]  y_a, y_t, y_w;
  logic        out_valid_a, out_valid_t, out_valid_w;
  logic [15:0] pix_cnt_a, pix_cnt_t;
  logic [3:0]  pix_cnt_w;

  int n_vec = 0;
  int n_err = 0;

  rgb_luma_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_y(y_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .pix_cnt(pix_cnt_a)
  );

  rgb_luma_pipe #(.ROUND(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready_t), .out_y(y_t),
    .out_valid(out_valid_t), .out_ready(out_ready), .pix_cnt(pix_cnt_t)
  );

  rgb_luma_pipe #(.CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready_w), .out_y(y_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .pix_cnt(pix_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coefficient vectors: expected rounded and truncated luma, by hand.
  logic [7:0] m_r  [6] = '{8'd255, 8'd255, 8'd0,   8'd0,   8'd0, 8'd1};
  logic [7:0] m_g  [6] = '{8'd255, 8'd0,   8'd255, 8'd0,   8'd0, 8'd1};
  logic [7:0] m_b  [6] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0, 8'd1};
  logic [7:0] m_ya [6] = '{8'd255, 8'd77,  8'd149, 8'd29,  8'd0, 8'd1};
  logic [7:0] m_yt [6] = '{8'd255, 8'd76,  8'd149, 8'd28,  8'd0, 8'd1};

  // Back-pressure stream with hand-computed rounded luma.
  logic [7:0] b_r [10] = '{8'd12, 8'd200, 8'd90,  8'd255, 8'd17,  8'd64, 8'd1, 8'd250, 8'd33,  8'd128};
  logic [7:0] b_g [10] = '{8'd34, 8'd100, 8'd180, 8'd128, 8'd240, 8'd64, 8'd2, 8'd5,   8'd77,  8'd128};
  logic [7:0] b_b [10] = '{8'd56, 8'd50,  8'd30,  8'd0,   8'd3,   8'd64, 8'd3, 8'd128, 8'd199, 8'd128};
  logic [7:0] b_y [10] = '{8'd30, 8'd124, 8'd136, 8'd152, 8'd146, 8'd64, 8'd2, 8'd93,  8'd78,  8'd128};
  bit         pat [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  int         tx, rx, tot;
  logic       in_x, out_x, stalled;
  logic [7:0] held;
  logic [31:0] tot_v;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
    tot = 0;

    // Asynchronous reset asserted mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid_a, 0);
    check("rst_async_inready", in_ready_a, 0);
    check("rst_async_cnt", pix_cnt_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_y", y_a, 0);
    check("rst_pix_cnt", pix_cnt_a, 0);
    check("rst_in_ready", in_ready_a, 1);

    // Back-to-back coefficient vectors with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 6);
      if (i < 6) begin
        in_r = m_r[i]; in_g = m_g[i]; in_b = m_b[i];
      end
      #1;
      check("main_in_ready", in_ready_a, 1);
      tick();
      if (i >= 1 && i <= 6) begin
        check("main_valid", out_valid_a, 1);
        check("main_y_round", y_a, m_ya[i-1]);
        check("main_y_trunc", y_t, m_yt[i-1]);
        $display("main vec %0d: y_round=%0d y_trunc=%0d", i-1, y_a, y_t);
      end else begin
        check("main_valid_idle", out_valid_a, 0);
      end
      check("main_pix_cnt", pix_cnt_a, (i == 0) ? 0 : i - 1);
    end
    tot = 6;

    // Random-ish stream under toggling back-pressure; source holds until accepted.
    tx = 0; rx = 0;
    for (int c = 0; c < 80 && rx < 10; c++) begin
      out_ready = pat[c % 5];
      in_valid  = (tx < 10);
      if (tx < 10) begin
        in_r = b_r[tx]; in_g = b_g[tx]; in_b = b_b[tx];
      end
      #1;
      if (!in_ready_a) check("bp_inready_drop", {30'd0, out_valid_a, out_ready}, 2);
      in_x    = in_valid && in_ready_a;
      out_x   = out_valid_a && out_ready;
      stalled = out_valid_a && !out_ready;
      held    = y_a;
      if (out_x) begin
        check("bp_y", y_a, b_y[rx]);
        $display("bp out %0d: y=%0d", rx, y_a);
        rx++;
        tot++;
      end
      tick();
      if (in_x) tx++;
      if (stalled) begin
        check("bp_hold_valid", out_valid_a, 1);
        check("bp_hold_y", y_a, held);
      end
      tot_v = tot;
      check("bp_pix_cnt", pix_cnt_a, tot_v[15:0]);
      check("bp_pix_cnt_w", pix_cnt_w, tot_v[3:0]);
    end
    check("bp_all_delivered", rx, 10);
    check("bp_wrapped_w", pix_cnt_w, 0);

    // Seventeenth transfer: narrow counter goes 0 -> 1.
    out_ready = 1'b1; in_valid = 1'b1;
    in_r = 8'd128; in_g = 8'd128; in_b = 8'd128;
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap_y", y_a, 128);
    tick();
    check("wrap_cnt_w", pix_cnt_w, 1);
    check("wrap_cnt_a", pix_cnt_a, 17);

    // Fill both stages under stall, then reset mid-cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    in_r = 8'd255; in_g = 8'd255; in_b = 8'd255;
    tick();
    in_r = 8'd0; in_g = 8'd255; in_b = 8'd0;
    tick();
    in_valid = 1'b0;
    check("full_valid", out_valid_a, 1);
    check("full_in_ready", in_ready_a, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid_a, 0);
    check("midrst_cnt", pix_cnt_a, 0);
    check("midrst_y", y_a, 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_r = 8'd10; in_g = 8'd20; in_b = 8'd30;
    #1;
    check("post_in_ready", in_ready_a, 1);
    tick();
    in_valid = 1'b0;
    check("post_lat_valid", out_valid_a, 0);
    tick();
    check("post_valid", out_valid_a, 1);
    check("post_y", y_a, 18);
    $display("post-reset out: y=%0d", y_a);
    tick();
    check("post_cnt_a", pix_cnt_a, 1);
    check("post_cnt_w", pix_cnt_w, 1);
    check("post_idle", out_valid_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
